// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared widths, FSM state type and index helper for eth_frame_arb_mux
package eth_arb_pkg;

  localparam int MAC_W  = 48;
  localparam int TYPE_W = 16;
  localparam int STAT_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// rtl/eth_rr_arbiter.sv - round-robin / fixed-priority request arbiter
// Combinational grant; pointer moves past the winner when advance_i is strobed.
module eth_rr_arbiter
  import eth_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter bit ARB_RR   = 1'b1,
  parameter int IDXW     = $clog2(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_i,
  input  logic                advance_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [IDXW-1:0]     grant_idx_o,
  output logic                grant_valid_o
);

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] win_idx;
  logic            win_found;

  // Fixed priority is simply a search that always starts at index 0.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] cidx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = ARB_RR ? int'(ptr_q) + i : i;
      if (cand >= NUM_REQS) cand = cand - NUM_REQS;
      cidx = IDXW'(cand);
      if (!win_found && req_i[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  assign grant_valid_o = win_found;
  assign grant_idx_o   = win_idx;
  assign grant_o       = win_found ? (NUM_REQS'(1) << win_idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && win_found) ptr_d = IDXW'(wrap_inc(int'(win_idx), NUM_REQS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/eth_frame_arb_mux.sv
// rtl/eth_frame_arb_mux.sv - N:1 Ethernet frame arbiter/mux with header handshake and payload skid buffer
// Optional per-channel frame counters when ETH_ARB_MUX_STATS_EN is defined.
module eth_frame_arb_mux
  import eth_arb_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int DATAW      = 8,
  parameter bit KEEP_EN    = (DATAW > 8),
  parameter int USER_WIDTH = 1,
  parameter bit ARB_RR     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            s_eth_hdr_valid,
  output logic [NUM_REQS-1:0]            s_eth_hdr_ready,
  input  logic [NUM_REQS*MAC_W-1:0]      s_eth_dest_mac,
  input  logic [NUM_REQS*MAC_W-1:0]      s_eth_src_mac,
  input  logic [NUM_REQS*TYPE_W-1:0]     s_eth_type,
  input  logic [NUM_REQS*DATAW-1:0]      s_eth_payload_tdata,
  input  logic [NUM_REQS*DATAW/8-1:0]    s_eth_payload_tkeep,
  input  logic [NUM_REQS-1:0]            s_eth_payload_tvalid,
  input  logic [NUM_REQS-1:0]            s_eth_payload_tlast,
  input  logic [NUM_REQS*USER_WIDTH-1:0] s_eth_payload_tuser,
  output logic [NUM_REQS-1:0]            s_eth_payload_tready,
  output logic                           m_eth_hdr_valid,
  input  logic                           m_eth_hdr_ready,
  output logic [MAC_W-1:0]               m_eth_dest_mac,
  output logic [MAC_W-1:0]               m_eth_src_mac,
  output logic [TYPE_W-1:0]              m_eth_type,
  output logic [DATAW-1:0]               m_eth_payload_tdata,
  output logic [DATAW/8-1:0]             m_eth_payload_tkeep,
  output logic                           m_eth_payload_tvalid,
  output logic                           m_eth_payload_tlast,
  output logic [USER_WIDTH-1:0]          m_eth_payload_tuser,
  input  logic                           m_eth_payload_tready,
  output logic                           busy
`ifdef ETH_ARB_MUX_STATS_EN
  ,
  output logic [NUM_REQS*STAT_W-1:0]     stat_frame_count
`endif
);

  localparam int IDXW   = $clog2(NUM_REQS);
  localparam int KEEP_W = DATAW / 8;
  localparam int BEAT_W = DATAW + KEEP_W + 1 + USER_WIDTH;

  arb_state_e          state_q, state_d;
  logic [IDXW-1:0]     gnt_q, gnt_d;
  logic [NUM_REQS-1:0] arb_grant;
  logic [IDXW-1:0]     arb_idx;
  logic                arb_valid;
  logic                hdr_fire;

  logic                hdr_valid_q, hdr_valid_d;
  logic [MAC_W-1:0]    dest_q, dest_d;
  logic [MAC_W-1:0]    src_q, src_d;
  logic [TYPE_W-1:0]   type_q, type_d;

  logic [NUM_REQS-1:0] s_tready_q, s_tready_d;
  logic                out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]   out_beat_q, out_beat_d;
  logic                skid_valid_q, skid_valid_d;
  logic [BEAT_W-1:0]   skid_beat_q, skid_beat_d;
  logic [KEEP_W-1:0]   in_keep;
  logic [BEAT_W-1:0]   in_beat;
  logic                in_accept;
  logic                in_last_acc;

  eth_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .ARB_RR   (ARB_RR),
    .IDXW     (IDXW)
  ) u_arb (
    .clk           (clk),
    .reset         (reset),
    .req_i         (s_eth_hdr_valid),
    .advance_i     (hdr_fire),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  // Header slot frees in the same cycle the downstream takes the old header.
  assign hdr_fire = (state_q == ST_IDLE) && arb_valid && (!hdr_valid_q || m_eth_hdr_ready) && !reset;
  assign s_eth_hdr_ready = hdr_fire ? arb_grant : '0;

  assign in_keep     = KEEP_EN ? s_eth_payload_tkeep[gnt_q*KEEP_W +: KEEP_W] : '0;
  assign in_beat     = {s_eth_payload_tdata[gnt_q*DATAW +: DATAW], in_keep,
                        s_eth_payload_tlast[gnt_q], s_eth_payload_tuser[gnt_q*USER_WIDTH +: USER_WIDTH]};
  assign in_accept   = |(s_tready_q & s_eth_payload_tvalid);
  assign in_last_acc = in_accept && in_beat[USER_WIDTH];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    hdr_valid_d  = hdr_valid_q;
    dest_d       = dest_q;
    src_d        = src_q;
    type_d       = type_q;
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    s_tready_d   = '0;

    if (hdr_valid_q && m_eth_hdr_ready) hdr_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hdr_fire) begin
          state_d     = ST_PAYLOAD;
          gnt_d       = arb_idx;
          hdr_valid_d = 1'b1;
          dest_d      = s_eth_dest_mac[arb_idx*MAC_W +: MAC_W];
          src_d       = s_eth_src_mac[arb_idx*MAC_W +: MAC_W];
          type_d      = s_eth_type[arb_idx*TYPE_W +: TYPE_W];
        end
      end
      ST_PAYLOAD: begin
        if (in_last_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Skid buffer: output register refills from skid first, then from input.
    if (!out_valid_q || m_eth_payload_tready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = in_accept;
        if (in_accept) skid_beat_d = in_beat;
      end else begin
        out_valid_d = in_accept;
        if (in_accept) out_beat_d = in_beat;
      end
    end else if (in_accept) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat;
    end

    // Offer tready only while the skid has room for one more beat.
    if (state_d == ST_PAYLOAD && !skid_valid_d) s_tready_d[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      hdr_valid_q  <= 1'b0;
      dest_q       <= '0;
      src_q        <= '0;
      type_q       <= '0;
      s_tready_q   <= '0;
      out_valid_q  <= 1'b0;
      out_beat_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_beat_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      hdr_valid_q  <= hdr_valid_d;
      dest_q       <= dest_d;
      src_q        <= src_d;
      type_q       <= type_d;
      s_tready_q   <= s_tready_d;
      out_valid_q  <= out_valid_d;
      out_beat_q   <= out_beat_d;
      skid_valid_q <= skid_valid_d;
      skid_beat_q  <= skid_beat_d;
    end
  end

  assign m_eth_hdr_valid      = hdr_valid_q;
  assign m_eth_dest_mac       = dest_q;
  assign m_eth_src_mac        = src_q;
  assign m_eth_type           = type_q;
  assign m_eth_payload_tvalid = out_valid_q;
  assign {m_eth_payload_tdata, m_eth_payload_tkeep, m_eth_payload_tlast, m_eth_payload_tuser} = out_beat_q;
  assign s_eth_payload_tready = s_tready_q;
  assign busy                 = (state_q == ST_PAYLOAD);

`ifdef ETH_ARB_MUX_STATS_EN
  logic [NUM_REQS*STAT_W-1:0] stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            stat_q <= '0;
    else if (in_last_acc) stat_q[gnt_q*STAT_W +: STAT_W] <= stat_q[gnt_q*STAT_W +: STAT_W] + STAT_W'(1);
  end

  assign stat_frame_count = stat_q;
`endif

endmodule

// File: tb/tb_eth_frame_arb_mux.sv
// tb/tb_eth_frame_arb_mux.sv - scoreboard bench for eth_frame_arb_mux (RR and fixed-priority instances)
module tb_eth_frame_arb_mux;
  import eth_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct packed {logic [47:0] d; logic [47:0] s; logic [15:0] t;} hdr_t;
  typedef struct packed {logic [7:0] data; logic last; logic user;} beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        hv[N];
  logic [47:0] dmac[N], smac[N];
  logic [15:0] typ[N];
  logic [7:0]  td[N];
  logic        tv[N], tl[N], tu[N];

  logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_tvalid, s_tlast, s_tready, s_tuser;
  logic [N*48-1:0] s_dest, s_src;
  logic [N*16-1:0] s_type;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tkeep;
  logic            m_hdr_valid, m_tvalid, m_tlast, busy;
  logic            m_hdr_ready = 1'b1;
  logic            m_tready = 1'b1;
  logic [47:0]     m_dest, m_src;
  logic [15:0]     m_type;
  logic [DW-1:0]   m_tdata;
  logic [0:0]      m_tkeep, m_tuser;
`ifdef ETH_ARB_MUX_STATS_EN
  logic [N*32-1:0] stat_cnt;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_hdr_valid[i]       = hv[i];
      s_dest[i*48 +: 48]   = dmac[i];
      s_src[i*48 +: 48]    = smac[i];
      s_type[i*16 +: 16]   = typ[i];
      s_tdata[i*DW +: DW]  = td[i];
      s_tvalid[i]          = tv[i];
      s_tlast[i]           = tl[i];
      s_tuser[i]           = tu[i];
    end
  end
  assign s_tkeep = '1;

  eth_frame_arb_mux #(.NUM_REQS(N), .DATAW(DW), .USER_WIDTH(1), .ARB_RR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_tdata(s_tdata), .s_eth_payload_tkeep(s_tkeep),
    .s_eth_payload_tvalid(s_tvalid), .s_eth_payload_tlast(s_tlast),
    .s_eth_payload_tuser(s_tuser), .s_eth_payload_tready(s_tready),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_tdata(m_tdata), .m_eth_payload_tkeep(m_tkeep),
    .m_eth_payload_tvalid(m_tvalid), .m_eth_payload_tlast(m_tlast),
    .m_eth_payload_tuser(m_tuser), .m_eth_payload_tready(m_tready),
    .busy(busy)
`ifdef ETH_ARB_MUX_STATS_EN
    , .stat_frame_count(stat_cnt)
`endif
  );

  // Fixed-priority instance: every channel always offers a one-beat frame body.
  logic [N-1:0]    hv2 = '0;
  logic [N-1:0]    s_hdr_ready2, s_tready2;
  logic [N*16-1:0] s_type2 = {16'd3, 16'd2, 16'd1, 16'd0};
  logic            m_hdr_valid2, m_tvalid2, m_tlast2, busy2;
  logic [47:0]     m_dest2, m_src2;
  logic [15:0]     m_type2;
  logic [DW-1:0]   m_tdata2;
  logic [0:0]      m_tkeep2, m_tuser2;
`ifdef ETH_ARB_MUX_STATS_EN
  logic [N*32-1:0] stat_cnt2;
`endif

  eth_frame_arb_mux #(.NUM_REQS(N), .DATAW(DW), .USER_WIDTH(1), .ARB_RR(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .s_eth_hdr_valid(hv2), .s_eth_hdr_ready(s_hdr_ready2),
    .s_eth_dest_mac({N*48{1'b0}}), .s_eth_src_mac({N*48{1'b0}}), .s_eth_type(s_type2),
    .s_eth_payload_tdata({N*DW{1'b0}}), .s_eth_payload_tkeep({N{1'b0}}),
    .s_eth_payload_tvalid({N{1'b1}}), .s_eth_payload_tlast({N{1'b1}}),
    .s_eth_payload_tuser({N{1'b0}}), .s_eth_payload_tready(s_tready2),
    .m_eth_hdr_valid(m_hdr_valid2), .m_eth_hdr_ready(1'b1),
    .m_eth_dest_mac(m_dest2), .m_eth_src_mac(m_src2), .m_eth_type(m_type2),
    .m_eth_payload_tdata(m_tdata2), .m_eth_payload_tkeep(m_tkeep2),
    .m_eth_payload_tvalid(m_tvalid2), .m_eth_payload_tlast(m_tlast2),
    .m_eth_payload_tuser(m_tuser2), .m_eth_payload_tready(1'b1),
    .busy(busy2)
`ifdef ETH_ARB_MUX_STATS_EN
    , .stat_frame_count(stat_cnt2)
`endif
  );

  int n_cmp = 0, n_err = 0;
  int out_beats = 0, out_lasts = 0, watch_ch = -1, g1 = 0, g3 = 0;
  bit keep_nz = 0, multi_tr = 0, other_tr = 0, bad3 = 0, t21_on = 0, abort = 0, toggle_mode = 0;
  hdr_t  exp_hdr[$];
  beat_t exp_beat[$];
  hdr_t  e_h;
  beat_t e_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic hdr_t mk_hdr(input int ch, input int fid);
    hdr_t h;
    h.d = {16'hD0D0, 8'(ch), 8'(fid), 16'h0001};
    h.s = {16'h5A5A, 8'(fid), 8'(ch), 16'h0002};
    h.t = 16'h0800 + 16'(ch);
    return h;
  endfunction

  function automatic beat_t mk_beat(input int ch, input int fid, input int b, input int nb);
    beat_t x;
    x.data = 8'(fid * 16 + b);
    x.last = (b == nb - 1);
    x.user = 1'(ch);
    return x;
  endfunction

  task automatic push_frame(input int ch, input int nb, input int fid);
    exp_hdr.push_back(mk_hdr(ch, fid));
    for (int b = 0; b < nb; b++) exp_beat.push_back(mk_beat(ch, fid, b, nb));
  endtask

  task automatic send_frame(input int ch, input int nb, input int fid);
    hdr_t h;
    int   guard;
    h = mk_hdr(ch, fid);
    dmac[ch] = h.d; smac[ch] = h.s; typ[ch] = h.t; hv[ch] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!s_hdr_ready[ch] && !abort && guard < 3000) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    hv[ch] = 1'b0;
    if (abort || guard >= 3000) return;
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      bt = mk_beat(ch, fid, b, nb);
      td[ch] = bt.data; tl[ch] = bt.last; tu[ch] = bt.user; tv[ch] = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!s_tready[ch] && !abort && guard < 3000) begin @(negedge clk); guard++; end
      @(posedge clk); #1;
      if (abort || guard >= 3000) break;
    end
    tv[ch] = 1'b0; tl[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((exp_hdr.size() != 0 || exp_beat.size() != 0) && c < budget) begin
      @(posedge clk); c++;
    end
    check_eq(tag, c < budget, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic finish_test();
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = toggle_mode ? ~m_tready : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (m_hdr_valid && m_hdr_ready) begin
        check_eq("hdr_expected", exp_hdr.size() != 0, 1);
        if (exp_hdr.size() != 0) begin
          e_h = exp_hdr.pop_front();
          check_eq("hdr_dest", m_dest, e_h.d);
          check_eq("hdr_src", m_src, e_h.s);
          check_eq("hdr_type", m_type, e_h.t);
        end
      end
      if (m_tvalid && m_tready) begin
        out_beats++;
        if (m_tlast) out_lasts++;
        if (m_tkeep != 0) keep_nz = 1'b1;
        check_eq("beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          e_b = exp_beat.pop_front();
          check_eq("beat_data", m_tdata, e_b.data);
          check_eq("beat_last", m_tlast, e_b.last);
          check_eq("beat_user", m_tuser, e_b.user);
        end
      end
      if ($countones(s_tready) > 1) multi_tr = 1'b1;
      if (watch_ch >= 0 && (s_tready & ~(N'(1) << watch_ch)) != 0) other_tr = 1'b1;
      if (t21_on) begin
        if (hv2[1] && s_hdr_ready2[1]) g1++;
        if (hv2[3] && s_hdr_ready2[3]) g3++;
        if (s_tready2[3]) bad3 = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   c;
    bit   hold_bad;
    hdr_t hh;
    for (int i = 0; i < N; i++) begin
      hv[i] = 0; tv[i] = 0; tl[i] = 0; tu[i] = 0; td[i] = 0;
      dmac[i] = 0; smac[i] = 0; typ[i] = 0;
    end
    reset = 1'b1;
    hv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hdr_valid", m_hdr_valid, 0);
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_s_hdr_ready", s_hdr_ready, 0);
    check_eq("rst_s_tready", s_tready, 0);
    check_eq("rst_dest", m_dest, 0);
    check_eq("rst_tdata", m_tdata, 0);
    hv[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Four simultaneous 3-beat frames: round-robin from 0.
    for (int ch = 0; ch < N; ch++) push_frame(ch, 3, ch + 1);
    out_beats = 0; out_lasts = 0;
    fork
      send_frame(0, 3, 1);
      send_frame(1, 3, 2);
      send_frame(2, 3, 3);
      send_frame(3, 3, 4);
    join_none
    wait_drain("t20_drain", 400);
    finish_test();
    check_eq("t20_beats", out_beats, 12);
    check_eq("t20_lasts", out_lasts, 4);
    check_eq("t20_tkeep_zero", keep_nz, 0);
    check_eq("t20_tready_onehot", multi_tr, 0);

    // 64-beat frame with output ready toggling every cycle.
    toggle_mode = 1'b1; watch_ch = 2; other_tr = 1'b0;
    out_beats = 0; out_lasts = 0;
    push_frame(2, 64, 5);
    fork send_frame(2, 64, 5); join_none
    wait_drain("t22_drain", 800);
    finish_test();
    toggle_mode = 1'b0; watch_ch = -1;
    check_eq("t22_beats", out_beats, 64);
    check_eq("t22_lasts", out_lasts, 1);
    check_eq("t22_other_tready", other_tr, 0);

    // Header held by downstream: payload still flows, next header blocked.
    m_hdr_ready = 1'b0;
    out_beats = 0;
    push_frame(3, 2, 6);
    push_frame(0, 2, 7);
    hh = mk_hdr(3, 6);
    fork send_frame(3, 2, 6); join_none
    repeat (2) @(posedge clk);
    #1;
    fork send_frame(0, 2, 7); join_none
    hold_bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (s_hdr_ready[0] || !m_hdr_valid || m_dest != hh.d || m_type != hh.t) hold_bad = 1'b1;
    end
    check_eq("t23_hold_stable", hold_bad, 0);
    check_eq("t23_hdr_valid", m_hdr_valid, 1);
    check_eq("t23_dest", m_dest, hh.d);
    check_eq("t23_payload_indep", out_beats, 2);
    @(posedge clk); #1;
    m_hdr_ready = 1'b1;
    wait_drain("t23_drain", 400);
    finish_test();

    // Reset in the middle of a 10-beat frame.
    out_beats = 0; out_lasts = 0;
    push_frame(1, 10, 8);
    fork send_frame(1, 10, 8); join_none
    c = 0;
    while (out_beats < 5 && c < 200) begin @(posedge clk); #1; c++; end
    check_eq("t24_reach_beat5", c < 200, 1);
    reset = 1'b1;
    #1;
    check_eq("t24_tvalid", m_tvalid, 0);
    check_eq("t24_hdr_valid", m_hdr_valid, 0);
    check_eq("t24_busy", busy, 0);
    check_eq("t24_s_tready", s_tready, 0);
    abort = 1'b1;
    exp_hdr.delete();
    exp_beat.delete();
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("t24_no_tlast", out_lasts, 0);
    // Pointer restarts at 0, so channel 0 wins over channel 2.
    out_beats = 0; out_lasts = 0;
    push_frame(0, 2, 10);
    push_frame(2, 4, 9);
    fork
      send_frame(2, 4, 9);
      send_frame(0, 2, 10);
    join_none
    wait_drain("t24_post_drain", 400);
    finish_test();
    check_eq("t24_post_beats", out_beats, 6);
    check_eq("t24_post_lasts", out_lasts, 2);

    // Fixed priority: channel 1 always wins over channel 3.
    t21_on = 1'b1;
    hv2 = 4'b1010;
    repeat (40) @(posedge clk);
    #1;
    hv2 = '0;
    t21_on = 1'b0;
    check_eq("t21_ch1_granted", g1 >= 10, 1);
    check_eq("t21_ch3_starved", g3, 0);
    check_eq("t21_ch3_tready", bad3, 0);

`ifdef ETH_ARB_MUX_STATS_EN
    for (int f = 0; f < 3; f++) begin
      push_frame(1, 2, 11 + f);
      send_frame(1, 2, 11 + f);
    end
    wait_drain("t25_drain", 200);
    check_eq("t25_count3", stat_cnt[63:32], 3);
    @(negedge clk);
    force dut.stat_q = 128'hFFFF_FFFF << 32;
    @(negedge clk);
    release dut.stat_q;
    push_frame(1, 2, 14);
    send_frame(1, 2, 14);
    wait_drain("t25_wrap_drain", 200);
    check_eq("t25_wrap", stat_cnt[63:32], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
